// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the clock-enable generator.
// Holds the control FSM encoding, default sizes and an increment calculator.
package clk_en_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_ACC_W       = 16;
    localparam int DEF_LOCK_CYCLES = 1024;

    // Rounded inc = f_target * 2^acc_w / f_ref; a zero reference yields a quiet channel.
    function automatic logic [31:0] calc_inc(input longint unsigned f_target_hz,
                                             input longint unsigned f_ref_hz,
                                             input int unsigned     acc_w);
        longint unsigned num;
        if (f_ref_hz == 0) begin
            return 32'd0;
        end
        num = (f_target_hz << acc_w) + (f_ref_hz >> 1);
        return 32'(num / f_ref_hz);
    endfunction

endpackage

// File: rtl/clk_en_gen_phase_acc_ch.sv
// One output channel: increment register, phase accumulator, registered strobe
// and square wave taken from the accumulator MSB.
module phase_acc_ch
    import clk_en_gen_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             inc_load_i,
    input  logic [ACC_W-1:0] inc_data_i,
    output logic             ce_o,
    output logic             sq_o
);

    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   accSum;

    // The accumulate always adds the increment held before this edge, so a
    // load in the same cycle only takes effect from the following cycle.
    always_comb begin
        inc_d  = inc_q;
        acc_d  = '0;
        ce_d   = 1'b0;
        accSum = {1'b0, acc_q} + {1'b0, inc_q};
        if (inc_load_i) begin
            inc_d = inc_data_i;
        end
        if (run_i) begin
            acc_d = accSum[ACC_W-1:0];
            ce_d  = accSum[ACC_W];
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q <= '0;
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            inc_q <= inc_d;
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce_o = ce_q;
    assign sq_o = acc_q[ACC_W-1];

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator behind the PLL: waits for a
// stable lock, then runs one phase accumulator per channel.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] inc_load,
    input  logic [ACC_W-1:0]  inc_data,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] sq,
    output logic              ready
);

    localparam int              CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    logic             sync1_q;
    logic             lock_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chRun;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    // Gating with lock_s as well as the state clears every channel on the
    // same edge that the FSM leaves RUN, rather than one edge later.
    assign chRun = (state_q == RUN) && lock_s_q;
    assign ready = (state_q == RUN);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        phase_acc_ch #(
            .ACC_W(ACC_W)
        ) u_ch (
            .refclk    (refclk),
            .rst_n     (rst_n),
            .run_i     (chRun && ch_en[c]),
            .inc_load_i(inc_load[c]),
            .inc_data_i(inc_data),
            .ce_o      (ce[c]),
            .sq_o      (sq[c])
        );
    end

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Multi-channel, parametrised clock-enable generator running on the PLL output clock. It waits for the PLL `locked` flag to be stable, then produces per-channel single-cycle enable strobes and 50%-duty square waves. Each channel's rate is fractional and set at run time by a phase-accumulator increment word. It sits directly behind the clock-processing PLL and drives the ADC sample strobes and other sub-rate timing, so no further PLL instances are needed for new rates.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent output channels (1..16).
- `ACC_W`, 16: phase-accumulator width in bits (8..32).
- `LOCK_CYCLES`, 1024: cycles that synchronised `pll_locked` must stay high before outputs run (≥1).

Ports:
- `refclk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pll_locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `ch_en` in NUM_CH: per-channel run enable.
- `inc_load` in NUM_CH: per-channel one-cycle strobe that loads the increment.
- `inc_data` in ACC_W: increment word, shared by all channels.
- `ce` out NUM_CH: one-cycle enable strobe per channel.
- `sq` out NUM_CH: square-wave output per channel, equal to the accumulator MSB.
- `ready` out 1: high while the block is in state RUN.

## Operation
- `pll_locked` passes through a 2-FF synchroniser to `lock_s`.
- Control FSM:
  - WAIT_LOCK → SETTLE when `lock_s` is high; the settle counter clears.
  - SETTLE: the counter increments each cycle. When it reaches LOCK_CYCLES-1, go to RUN.
  - RUN: operate channels. Low `lock_s` in SETTLE or RUN → WAIT_LOCK.
- Per channel, the increment register `inc[c]` loads `inc_data` when `inc_load[c]` is high, in any state. It resets to 0.
- Accumulator `acc[c]` (ACC_W bits) updates only when the state is RUN and `ch_en[c]` is high:
  - `{carry, acc} <= acc + inc[c]`;
  - `ce[c] <= carry`.
- Accumulator hold and clear:
  - In RUN with `ch_en[c]` low, `acc[c]` clears to 0 and `ce[c]` is 0.
  - In any other state, every `acc` clears to 0 and every `ce` is 0.
- `sq[c] = acc[c][ACC_W-1]`.
- Output frequency is f_refclk·inc/2^ACC_W, and the long-run average strobe rate is exact. `inc` = 0 holds the output quiet; the maximum `inc` of 2^ACC_W−1 gives a strobe on every cycle except one per 2^ACC_W.
- Simultaneous `inc_load[c]` and an accumulate in the same cycle: the accumulate uses the old `inc`, and the new value applies from the next cycle. No accumulator reset on load.
- Several `inc_load` bits high at once: all selected channels load the same `inc_data`.
- Loss of lock mid-run: all `ce`/`sq` outputs are low on the edge after `lock_s` falls. The block restarts from WAIT_LOCK with a full settle period.

## Timing
- Reset values: `ready`=0, `ce`=0, `sq`=0, state WAIT_LOCK, all counters, increments and accumulators 0, synchroniser 0.
- `pll_locked` rising before edge k:
  - `lock_s` is high after edge k+1;
  - SETTLE is entered at edge k+2;
  - RUN and `ready`=1 follow at edge k+1+LOCK_CYCLES+1.
- `pll_locked` falling before edge k: `ready`, `ce` and `sq` are 0 after edge k+2.
- `ce` is registered: high for exactly one cycle, in the cycle after the accumulator overflows.
- The first RUN edge performs the first accumulate. With `inc` = 2^(ACC_W−2), the first `ce` is high after the 4th RUN edge.
- `ch_en[c]` falling: `ce[c]`/`sq[c]` are 0 after the next edge. Rising: accumulation restarts from 0.

## Structure
- Package `clk_en_gen_pkg` holds:
  - the FSM state enum `{WAIT_LOCK, SETTLE, RUN}`;
  - default ACC_W/NUM_CH constants;
  - a function computing `inc` from the target and reference frequency, for benches and callers.
- Sub-module `phase_acc_ch` contains one channel: the `inc` register, accumulator, `ce` and `sq`. It is instantiated NUM_CH times in a generate loop.
- The top level holds the synchroniser, FSM and settle counter.

## Test plan
- Reset and lock, LOCK_CYCLES=8:
  - assert `rst_n` low, then release;
  - raise `pll_locked` before edge 0;
  - required: `ready`=0 through edge 9, `ready`=1 after edge 10.
- Fixed rate, ACC_W=16:
  - load `inc`=0x4000 on ch0 and 0x8000 on ch1, both enabled;
  - required: ch0 `ce` every 4 cycles with `sq` 2 high / 2 low;
  - required: ch1 `ce` every 2 cycles;
  - required: ch2 with `inc`=0 never strobes.
- Fractional rate:
  - load `inc`=0x3000 (3/16);
  - required: exactly 3 `ce` pulses in every 16 consecutive RUN cycles, with spacing 5/5/6 cycles in some rotation.
- Load collision:
  - pulse `inc_load` in the same cycle that ch0 would overflow, 0x4000 → 0x2000;
  - required: that strobe still fires, then the period becomes 8.
- Lock loss:
  - drop `pll_locked` for 1 cycle mid-run;
  - required: `ready`/`ce`/`sq` are 0 within 2 edges, and `ready` returns only LOCK_CYCLES+1 edges after `lock_s` is high again.
- Async reset mid-run:
  - pull `rst_n` low between clock edges;
  - required: all outputs are 0 immediately, without a clock edge, and the stored `inc` values are cleared.
